// File: rtl/cksum_sched.sv
`default_nettype none
// ============================================================================
// Module   : cksum_sched
// Function : Round-robin sharing of one cksum engine and its SRAM port.
// Revision : 1.0  initial release
// ============================================================================
module cksum_sched #(
  parameter int N_REQ = 4,
  parameter int IDX_W = 2
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [N_REQ-1:0]     req_i,
  input  logic [32*N_REQ-1:0]  req_addr_i,
  input  logic [32*N_REQ-1:0]  req_len_i,
  input  logic [32*N_REQ-1:0]  req_dst_i,
  output logic [N_REQ-1:0]     done_o,
  output logic [15:0]          cksum_o,
  output logic                 busy_o,
  output logic                 eng_start_o,
  output logic [31:0]          eng_addr_o,
  output logic [31:0]          eng_len_o,
  input  logic                 eng_ready_i,
  input  logic [15:0]          eng_val_i,
  input  logic                 eng_sram_ce_i,
  input  logic                 eng_sram_we_i,
  input  logic [31:0]          eng_sram_addr_i,
  input  logic [3:0]           eng_sram_sel_i,
  input  logic [31:0]          eng_sram_data_i,
  output logic [31:0]          eng_sram_data_o,
  output logic                 sram_ce_o,
  output logic                 sram_we_o,
  output logic [31:0]          sram_addr_o,
  output logic [3:0]           sram_sel_o,
  output logic [31:0]          sram_data_o,
  input  logic [31:0]          sram_data_i
);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_ISSUE = 3'd1,
    S_WAIT  = 3'd2,
    S_WB    = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  localparam logic [IDX_W:0]   c_n    = (IDX_W+1)'(N_REQ);
  localparam logic [IDX_W-1:0] c_last = IDX_W'(N_REQ - 1);
  localparam logic [N_REQ-1:0] c_one  = N_REQ'(1);

  state_t           r_state;
  logic [IDX_W-1:0] r_rr_ptr;
  logic [IDX_W-1:0] r_idx;
  logic [31:0]      r_dst;
  logic [15:0]      r_val;

  logic             w_gnt_vld;
  logic [IDX_W-1:0] w_gnt_idx;
  logic [IDX_W:0]   w_cand;
  logic [31:0]      w_addr_sel;
  logic [31:0]      w_len_msk;
  logic [31:0]      w_dst_sel;
  logic             w_unused;

  // Scan offsets from far to near so the nearest requester at/after the pointer wins.
  always_comb begin
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    w_cand    = '0;
    for (int k = N_REQ - 1; k >= 0; k--) begin
      w_cand = {1'b0, r_rr_ptr} + (IDX_W+1)'(k);
      if (w_cand >= c_n) begin
        w_cand = w_cand - c_n;
      end
      if (req_i[w_cand[IDX_W-1:0]]) begin
        w_gnt_vld = 1'b1;
        w_gnt_idx = w_cand[IDX_W-1:0];
      end
    end
  end

  assign w_addr_sel = req_addr_i[{w_gnt_idx, 5'd0} +: 32];
  assign w_len_msk  = {req_len_i[{w_gnt_idx, 5'd0} + 1 +: 31], 1'b0};
  assign w_dst_sel  = req_dst_i[{w_gnt_idx, 5'd0} +: 32];
  assign w_unused   = r_dst[0];

  assign busy_o          = (r_state != S_IDLE);
  assign eng_sram_data_o = sram_data_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state     <= S_IDLE;
      r_rr_ptr    <= '0;
      r_idx       <= '0;
      r_dst       <= '0;
      r_val       <= '0;
      eng_start_o <= 1'b0;
      eng_addr_o  <= '0;
      eng_len_o   <= '0;
      done_o      <= '0;
      cksum_o     <= '0;
    end else begin
      done_o <= '0;
      case (r_state)
        S_IDLE: begin
          if (w_gnt_vld) begin
            r_idx      <= w_gnt_idx;
            r_dst      <= w_dst_sel;
            eng_addr_o <= w_addr_sel;
            eng_len_o  <= w_len_msk;
            r_rr_ptr   <= (w_gnt_idx == c_last) ? '0 : w_gnt_idx + 1'b1;
            if (w_len_msk == 32'd0) begin
              r_val   <= 16'hFFFF;
              r_state <= S_WB;
            end else begin
              eng_start_o <= 1'b1;
              r_state     <= S_ISSUE;
            end
          end
        end
        // Wait out any ready level left over from the previous job.
        S_ISSUE: begin
          if (!eng_ready_i) begin
            r_state <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (eng_ready_i) begin
            r_val       <= eng_val_i;
            eng_start_o <= 1'b0;
            r_state     <= S_WB;
          end
        end
        S_WB: begin
          done_o  <= c_one << r_idx;
          cksum_o <= r_val;
          r_state <= S_DONE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  always_comb begin
    sram_ce_o   = 1'b0;
    sram_we_o   = 1'b0;
    sram_addr_o = '0;
    sram_sel_o  = '0;
    sram_data_o = '0;
    case (r_state)
      S_ISSUE, S_WAIT: begin
        sram_ce_o   = eng_sram_ce_i;
        sram_we_o   = eng_sram_we_i;
        sram_addr_o = eng_sram_addr_i;
        sram_sel_o  = eng_sram_sel_i;
        sram_data_o = eng_sram_data_i;
      end
      S_WB: begin
        sram_ce_o   = 1'b1;
        sram_we_o   = 1'b1;
        sram_addr_o = {r_dst[31:2], 2'b00};
        if (r_dst[1]) begin
          sram_sel_o  = 4'b0011;
          sram_data_o = {16'h0000, r_val};
        end else begin
          sram_sel_o  = 4'b1100;
          sram_data_o = {r_val, 16'h0000};
        end
      end
      default: begin
      end
    endcase
  end

endmodule
`default_nettype wire

// File: tb/tb_cksum_sched.sv
`default_nettype none
// Bench for cksum_sched: behavioural engine and SRAM, scoreboard of expected
// completions pushed at request time and popped when done_o fires.
module tb_cksum_sched;
  localparam int N = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [N-1:0]      req_i;
  logic [32*N-1:0]   req_addr_i, req_len_i, req_dst_i;
  logic [N-1:0]      done_o;
  logic [15:0]       cksum_o;
  logic              busy_o;
  logic              eng_start_o;
  logic [31:0]       eng_addr_o, eng_len_o;
  logic              eng_ready_i;
  logic [15:0]       eng_val_i;
  logic              eng_sram_ce_i, eng_sram_we_i;
  logic [31:0]       eng_sram_addr_i;
  logic [3:0]        eng_sram_sel_i;
  logic [31:0]       eng_sram_data_i, eng_sram_data_o;
  logic              sram_ce_o, sram_we_o;
  logic [31:0]       sram_addr_o;
  logic [3:0]        sram_sel_o;
  logic [31:0]       sram_data_o, sram_data_i;

  always #5 clk = ~clk;

  cksum_sched #(.N_REQ(N), .IDX_W(2)) dut (
    .clk(clk), .rst(rst), .req_i(req_i), .req_addr_i(req_addr_i),
    .req_len_i(req_len_i), .req_dst_i(req_dst_i), .done_o(done_o),
    .cksum_o(cksum_o), .busy_o(busy_o), .eng_start_o(eng_start_o),
    .eng_addr_o(eng_addr_o), .eng_len_o(eng_len_o), .eng_ready_i(eng_ready_i),
    .eng_val_i(eng_val_i), .eng_sram_ce_i(eng_sram_ce_i),
    .eng_sram_we_i(eng_sram_we_i), .eng_sram_addr_i(eng_sram_addr_i),
    .eng_sram_sel_i(eng_sram_sel_i), .eng_sram_data_i(eng_sram_data_i),
    .eng_sram_data_o(eng_sram_data_o), .sram_ce_o(sram_ce_o),
    .sram_we_o(sram_we_o), .sram_addr_o(sram_addr_o), .sram_sel_o(sram_sel_o),
    .sram_data_o(sram_data_o), .sram_data_i(sram_data_i)
  );

  typedef struct {
    int          idx;
    logic [15:0] cks;
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } exp_t;
  typedef struct {
    logic [31:0] addr;
    logic [3:0]  sel;
    logic [31:0] data;
  } wr_t;

  exp_t exp_q[$];
  wr_t  wr_q[$];
  int   errors = 0;
  int   checks = 0;

  // SRAM: asynchronous read; writes are only recorded so field contents stay fixed.
  logic [31:0] mem [0:1023];
  assign sram_data_i = mem[sram_addr_o[11:2]];
  always @(posedge clk) begin
    if (sram_ce_o && sram_we_o) begin
      wr_t w;
      w.addr = sram_addr_o; w.sel = sram_sel_o; w.data = sram_data_o;
      wr_q.push_back(w);
    end
  end

  // Engine: one halfword per cycle through the shared port; ready held in its DONE state.
  localparam logic [1:0] E_IDLE = 2'd0, E_RUN = 2'd1, E_DONE = 2'd2;
  logic [1:0]  e_state;
  logic [31:0] e_addr, e_len, e_off, e_sum;
  logic [15:0] e_val;
  logic        e_ready;
  logic        sticky = 1'b0;
  logic [31:0] e_rd;
  logic [15:0] e_half;
  assign e_rd            = e_addr + e_off;
  assign e_half          = e_rd[1] ? eng_sram_data_o[15:0] : eng_sram_data_o[31:16];
  assign eng_sram_ce_i   = (e_state == E_RUN);
  assign eng_sram_we_i   = 1'b0;
  assign eng_sram_addr_i = {e_rd[31:2], 2'b00};
  assign eng_sram_sel_i  = 4'hF;
  assign eng_sram_data_i = 32'h0;
  assign eng_ready_i     = e_ready;
  assign eng_val_i       = e_val;

  function automatic logic [15:0] fold(input logic [31:0] s);
    logic [31:0] t;
    t = {16'h0, s[15:0]} + {16'h0, s[31:16]};
    t = {16'h0, t[15:0]} + {16'h0, t[31:16]};
    return ~t[15:0];
  endfunction

  always @(posedge clk or negedge rst) begin
    if (!rst) begin
      e_state <= E_IDLE; e_ready <= 1'b0; e_val <= '0;
      e_addr <= '0; e_len <= '0; e_off <= '0; e_sum <= '0;
    end else begin
      case (e_state)
        E_IDLE: begin
          if (eng_start_o) begin
            e_addr <= eng_addr_o; e_len <= eng_len_o; e_off <= '0; e_sum <= '0;
            e_ready <= 1'b0; e_state <= E_RUN;
          end else if (!sticky) begin
            e_ready <= 1'b0;
          end
        end
        E_RUN: begin
          e_sum <= e_sum + {16'h0, e_half};
          e_off <= e_off + 32'd2;
          if (e_off + 32'd2 >= e_len) begin
            e_val <= fold(e_sum + {16'h0, e_half});
            e_ready <= 1'b1; e_state <= E_DONE;
          end
        end
        default: begin
          if (!eng_start_o) begin
            e_state <= E_IDLE;
            if (!sticky) e_ready <= 1'b0;
          end
        end
      endcase
    end
  end

  // Start-gap monitor: length of the low run preceding each start rise.
  int   start_rises = 0;
  int   low_cnt = 0;
  int   last_gap = 0;
  logic start_q = 1'b0;
  always @(posedge clk) begin
    if (!eng_start_o) begin
      low_cnt <= low_cnt + 1;
    end else begin
      if (!start_q) begin
        start_rises <= start_rises + 1;
        last_gap <= low_cnt;
      end
      low_cnt <= 0;
    end
    start_q <= eng_start_o;
  end

  function automatic logic [15:0] ref_cksum(input logic [31:0] a, input logic [31:0] l);
    logic [31:0] s, p, w;
    s = 0;
    for (int b = 0; b + 1 < int'(l); b += 2) begin
      p = a + b;
      w = mem[p[11:2]];
      s = s + {16'h0, (p[1] ? w[15:0] : w[31:16])};
    end
    return fold(s);
  endfunction

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] l,
                         input logic [31:0] d);
    req_addr_i[32*i +: 32] = a;
    req_len_i[32*i +: 32]  = l;
    req_dst_i[32*i +: 32]  = d;
    req_i[i] = 1'b1;
  endtask

  task automatic push_exp(input int i, input logic [15:0] c, input logic [31:0] d);
    exp_t e;
    e.idx  = i;
    e.cks  = c;
    e.addr = {d[31:2], 2'b00};
    e.sel  = d[1] ? 4'b0011 : 4'b1100;
    e.data = d[1] ? {16'h0, c} : {c, 16'h0};
    exp_q.push_back(e);
  endtask

  task automatic wait_done(input bit hold, output logic [N-1:0] d, output int lat);
    d = '0;
    lat = 0;
    for (int c = 1; c <= 300; c++) begin
      @(negedge clk);
      if (done_o != '0) begin
        d = done_o;
        lat = c;
        if (!hold) req_i = req_i & ~done_o;
        return;
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    req_i = '0; req_addr_i = '0; req_len_i = '0; req_dst_i = '0;
    repeat (2) @(negedge clk);
    checks++; if (done_o !== 4'b0) begin errors++; $display("FAIL reset_done: got %b want 0000", done_o); end
    checks++; if (cksum_o !== 16'h0) begin errors++; $display("FAIL reset_cksum: got %h want 0000", cksum_o); end
    checks++; if ({busy_o, eng_start_o} !== 2'b00) begin errors++; $display("FAIL reset_busy_start: got %b want 00", {busy_o, eng_start_o}); end
    checks++; if ({eng_addr_o, eng_len_o} !== 64'h0) begin errors++; $display("FAIL reset_eng: got %h want 0", {eng_addr_o, eng_len_o}); end
    checks++; if ({sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o} !== 70'h0) begin
      errors++; $display("FAIL reset_sram: got %h want 0", {sram_ce_o, sram_we_o, sram_addr_o, sram_sel_o, sram_data_o}); end
    rst = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_ipv4();
    logic [N-1:0] d; int lat; exp_t e; wr_t w;
    @(negedge clk);
    set_req(0, 32'h100, 32'd20, 32'h10A);
    push_exp(0, 16'hB861, 32'h10A);
    @(negedge clk);
    checks++; if ({eng_start_o, eng_addr_o, eng_len_o} !== {1'b1, 32'h100, 32'd20}) begin
      errors++; $display("FAIL ipv4_issue: got %b %h %h want 1 00000100 00000014", eng_start_o, eng_addr_o, eng_len_o); end
    @(negedge clk);
    checks++; if ({sram_ce_o, sram_we_o, sram_addr_o} !== {2'b10, 32'h100} || eng_sram_data_o !== 32'h45000073) begin
      errors++; $display("FAIL ipv4_mux: got ce=%b we=%b a=%h rd=%h want 1 0 00000100 45000073", sram_ce_o, sram_we_o, sram_addr_o, eng_sram_data_o); end
    wait_done(1'b0, d, lat);
    e = exp_q.pop_front();
    checks++; if (d !== 4'b0001) begin errors++; $display("FAIL ipv4_done: got %b want 0001", d); end
    checks++; if (cksum_o !== e.cks) begin errors++; $display("FAIL ipv4_cksum: got %h want %h", cksum_o, e.cks); end
    checks++;
    if (wr_q.size() != 1) begin errors++; $display("FAIL ipv4_wb_count: got %0d want 1", wr_q.size()); wr_q.delete(); end
    else begin
      w = wr_q.pop_front();
      if ({w.addr, w.sel, w.data} !== {32'h108, 4'b0011, 32'h0000B861}) begin
        errors++; $display("FAIL ipv4_wb: got %h %b %h want 00000108 0011 0000b861", w.addr, w.sel, w.data); end
    end
  endtask

  task automatic test_upper();
    logic [N-1:0] d; int lat; exp_t e; wr_t w;
    @(negedge clk);
    set_req(0, 32'h100, 32'd20, 32'h108);
    push_exp(0, 16'hB861, 32'h108);
    wait_done(1'b0, d, lat);
    e = exp_q.pop_front();
    checks++; if (d !== 4'b0001 || cksum_o !== e.cks) begin errors++; $display("FAIL upper_done: got %b %h want 0001 %h", d, cksum_o, e.cks); end
    checks++;
    if (wr_q.size() == 0) begin errors++; $display("FAIL upper_wb: got none want one write"); end
    else begin
      w = wr_q.pop_front();
      if ({w.addr, w.sel, w.data} !== {32'h108, 4'b1100, 32'hB8610000}) begin
        errors++; $display("FAIL upper_wb: got %h %b %h want 00000108 1100 b8610000", w.addr, w.sel, w.data); end
    end
  endtask

  task automatic test_round_robin();
    logic [N-1:0] d; int lat; exp_t e; wr_t w;
    int order [5] = '{0, 1, 2, 3, 0};
    @(negedge clk); rst = 1'b0;
    @(negedge clk); rst = 1'b1;
    for (int i = 0; i < N; i++) set_req(i, 32'h100 + 32'(4*i), 32'd8, 32'h300 + 32'(4*i));
    for (int k = 0; k < 5; k++) push_exp(order[k], ref_cksum(32'h100 + 32'(4*order[k]), 32'd8), 32'h300 + 32'(4*order[k]));
    for (int k = 0; k < 5; k++) begin
      wait_done(1'b1, d, lat);
      e = exp_q.pop_front();
      checks++; if (d !== (4'b0001 << e.idx)) begin errors++; $display("FAIL rr_grant%0d: got %b want %b", k, d, 4'b0001 << e.idx); end
      checks++; if (cksum_o !== e.cks) begin errors++; $display("FAIL rr_cksum%0d: got %h want %h", k, cksum_o, e.cks); end
      checks++;
      if (wr_q.size() == 0) begin errors++; $display("FAIL rr_wb%0d: got none want one write", k); end
      else begin
        w = wr_q.pop_front();
        if ({w.addr, w.sel, w.data} !== {e.addr, e.sel, e.data}) begin
          errors++; $display("FAIL rr_wb%0d: got %h %b %h want %h %b %h", k, w.addr, w.sel, w.data, e.addr, e.sel, e.data); end
      end
    end
    req_i = '0;
    @(negedge clk);
  endtask

  task automatic test_zero_len();
    logic [N-1:0] d; int lat; exp_t e; wr_t w; int r0;
    logic [31:0] lens [2] = '{32'd0, 32'd1};
    for (int k = 0; k < 2; k++) begin
      @(negedge clk);
      r0 = start_rises;
      set_req(2, 32'h180, lens[k], 32'h200);
      push_exp(2, 16'hFFFF, 32'h200);
      wait_done(1'b0, d, lat);
      e = exp_q.pop_front();
      checks++; if (lat !== 2) begin errors++; $display("FAIL zlen%0d_latency: got %0d want 2", k, lat); end
      checks++; if (d !== 4'b0100 || cksum_o !== 16'hFFFF) begin errors++; $display("FAIL zlen%0d_done: got %b %h want 0100 ffff", k, d, cksum_o); end
      checks++; if (start_rises !== r0) begin errors++; $display("FAIL zlen%0d_nostart: got %0d starts want 0", k, start_rises - r0); end
      checks++;
      if (wr_q.size() == 0) begin errors++; $display("FAIL zlen%0d_wb: got none want one write", k); end
      else begin
        w = wr_q.pop_front();
        if ({w.addr, w.sel, w.data} !== {32'h200, 4'b1100, 32'hFFFF0000} || e.cks !== 16'hFFFF) begin
          errors++; $display("FAIL zlen%0d_wb: got %h %b %h want 00000200 1100 ffff0000", k, w.addr, w.sel, w.data); end
      end
    end
  endtask

  task automatic test_back_to_back();
    logic [N-1:0] d; int lat; exp_t e; wr_t w; int r0;
    sticky = 1'b1;
    @(negedge clk);
    r0 = start_rises;
    set_req(1, 32'h100, 32'd20, 32'h310);
    set_req(2, 32'h100, 32'd8, 32'h314);
    push_exp(1, ref_cksum(32'h100, 32'd20), 32'h310);
    push_exp(2, ref_cksum(32'h100, 32'd8), 32'h314);
    for (int k = 0; k < 2; k++) begin
      wait_done(1'b0, d, lat);
      e = exp_q.pop_front();
      checks++; if (d !== (4'b0001 << e.idx) || cksum_o !== e.cks) begin
        errors++; $display("FAIL b2b_job%0d: got %b %h want %b %h", k, d, cksum_o, 4'b0001 << e.idx, e.cks); end
      if (wr_q.size() != 0) w = wr_q.pop_front();
    end
    checks++; if (start_rises - r0 !== 2) begin errors++; $display("FAIL b2b_starts: got %0d want 2", start_rises - r0); end
    checks++; if (last_gap < 3) begin errors++; $display("FAIL b2b_gap: got %0d want >=3", last_gap); end
    sticky = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_reset_mid();
    logic [N-1:0] d; int lat; exp_t e; wr_t w;
    @(negedge clk);
    wr_q.delete();
    set_req(3, 32'h100, 32'd20, 32'h320);
    repeat (3) @(negedge clk);
    checks++; if (!(busy_o && eng_start_o)) begin errors++; $display("FAIL mid_prereq: got busy=%b start=%b want 1 1", busy_o, eng_start_o); end
    rst = 1'b0;
    #1;
    checks++; if ({busy_o, eng_start_o, done_o, sram_ce_o, sram_we_o} !== 8'h0 || {eng_addr_o, eng_len_o} !== 64'h0) begin
      errors++; $display("FAIL mid_reset: got busy=%b start=%b done=%b ce=%b addr=%h want all 0", busy_o, eng_start_o, done_o, sram_ce_o, eng_addr_o); end
    req_i = '0;
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++; if (wr_q.size() != 0 || done_o !== 4'b0) begin errors++; $display("FAIL mid_abandon: got %0d writes done=%b want 0 0000", wr_q.size(), done_o); end
    set_req(0, 32'h104, 32'd12, 32'h32A);
    push_exp(0, ref_cksum(32'h104, 32'd12), 32'h32A);
    wait_done(1'b0, d, lat);
    e = exp_q.pop_front();
    checks++; if (d !== 4'b0001 || cksum_o !== e.cks) begin errors++; $display("FAIL mid_after: got %b %h want 0001 %h", d, cksum_o, e.cks); end
    checks++;
    if (wr_q.size() == 0) begin errors++; $display("FAIL mid_after_wb: got none want one write"); end
    else begin
      w = wr_q.pop_front();
      if ({w.addr, w.sel, w.data} !== {e.addr, e.sel, e.data}) begin
        errors++; $display("FAIL mid_after_wb: got %h %b %h want %h %b %h", w.addr, w.sel, w.data, e.addr, e.sel, e.data); end
    end
  endtask

  initial begin
    for (int i = 0; i < 1024; i++) mem[i] = 32'h0;
    mem[32'h100 >> 2] = 32'h45000073;
    mem[32'h104 >> 2] = 32'h00004000;
    mem[32'h108 >> 2] = 32'h40110000;
    mem[32'h10C >> 2] = 32'hC0A80001;
    mem[32'h110 >> 2] = 32'hC0A800C7;
    test_reset();
    test_ipv4();
    test_upper();
    test_round_robin();
    test_zero_len();
    test_back_to_back();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule
`default_nettype wire
